// File: rtl/addr_dec_pkg.sv
// Shared width helpers for the TCDM address decoder / response mux.
// No ports; imported by the interface, the counter and the top level.
package addr_dec_pkg;

  // Width of a slave index.
  function automatic int unsigned sel_width(input int unsigned num_slave);
    return (num_slave > 1) ? $clog2(num_slave) : 1;
  endfunction

  // Width of a counter that has to hold 0..max_outstanding inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/addr_dec_resp_mux_vlat_if.sv
// Bundle of all bus signals around addr_dec_resp_mux_vlat.
// Signal names follow the block's own port view (_i into the block, _o out of it).
//   master side : req_i, add_i, data_i -> gnt_o, rvld_o, rdata_o, err_o, outstanding_o
//   slave side  : req_o, data_o -> ; gnt_i, rvld_i, rdata_i ->
// Modport slave is the decoder's view, modport master is the environment's view.
interface addr_dec_resp_mux_vlat_if #(
  parameter int unsigned NumSlave       = 32,
  parameter int unsigned ReqDataWidth   = 32,
  parameter int unsigned RespDataWidth  = 32,
  parameter int unsigned MaxOutstanding = 4
);
  import addr_dec_pkg::*;

  localparam int unsigned SelW = sel_width(NumSlave);
  localparam int unsigned CntW = cnt_width(MaxOutstanding);

  logic                                         req_i;
  logic [SelW-1:0]                              add_i;
  logic [ReqDataWidth-1:0]                      data_i;
  logic                                         gnt_o;
  logic                                         rvld_o;
  logic [RespDataWidth-1:0]                     rdata_o;
  logic                                         err_o;
  logic [CntW-1:0]                              outstanding_o;
  logic [NumSlave-1:0]                          req_o;
  logic [NumSlave-1:0]                          gnt_i;
  logic [NumSlave-1:0][ReqDataWidth-1:0]        data_o;
  logic [NumSlave-1:0]                          rvld_i;
  logic [NumSlave-1:0][RespDataWidth-1:0]       rdata_i;

  modport slave (
    input  req_i, add_i, data_i, gnt_i, rvld_i, rdata_i,
    output gnt_o, rvld_o, rdata_o, err_o, outstanding_o, req_o, data_o
  );

  modport master (
    output req_i, add_i, data_i, gnt_i, rvld_i, rdata_i,
    input  gnt_o, rvld_o, rdata_o, err_o, outstanding_o, req_o, data_o
  );

endinterface

// File: rtl/outstanding_cnt.sv
// Up/down in-flight counter with full/empty flags. Increments are ignored
// when full and decrements when empty, so the count can never wrap.
// Ports: clk_i, rst_i (async, active-high), inc_i, dec_i,
//        cnt_o (current count), full_o (cnt==Max), empty_o (cnt==0).
module outstanding_cnt
  import addr_dec_pkg::*;
#(
  parameter int unsigned Max = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      inc_i,
  input  logic                      dec_i,
  output logic [cnt_width(Max)-1:0] cnt_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int unsigned W = cnt_width(Max);

  logic [W-1:0] cnt_q, cnt_d;

  assign full_o  = (cnt_q == W'(Max));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && !full_o) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec_i && !inc_i && !empty_o) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/addr_dec_resp_mux_vlat.sv
// Per-master TCDM address decoder and in-order response mux for slaves with
// variable response latency. Up to MaxOutstanding requests may be in flight,
// all to the same slave; switching target waits until everything has drained.
// Ports: clk_i, rst_i (async, active-high) plus the bus interface (slave modport):
//   master side: req_i/add_i/data_i in, gnt_o/rvld_o/rdata_o/err_o/outstanding_o out
//   slave side : req_o (one-hot)/data_o (broadcast) out, gnt_i/rvld_i/rdata_i in
module addr_dec_resp_mux_vlat
  import addr_dec_pkg::*;
#(
  parameter int unsigned NumSlave       = 32,
  parameter int unsigned ReqDataWidth   = 32,
  parameter int unsigned RespDataWidth  = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned RespReg        = 0
) (
  input logic                      clk_i,
  input logic                      rst_i,
  addr_dec_resp_mux_vlat_if.slave  bus
);

  localparam int unsigned SelW = sel_width(NumSlave);
  localparam int unsigned CntW = cnt_width(MaxOutstanding);

  logic [CntW-1:0]          cnt;
  logic                     full, empty;
  logic                     stall, accept, resp_ok, spurious;
  logic [NumSlave-1:0]      req_dec, tgt_oh;
  logic                     rvld_sel;
  logic [RespDataWidth-1:0] rdata_sel;
  logic [SelW-1:0]          tgt_q, tgt_d;
  logic                     err_q, err_d;

  always_comb begin
    // Stall only looks at registered state, so rvld_i never reaches req_o/gnt_o.
    stall     = full | (~empty & (bus.add_i != tgt_q));
    req_dec   = '0;
    tgt_oh    = '0;
    rvld_sel  = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NumSlave; i++) begin
      // rst_i gating keeps req_o/gnt_o low for the whole reset window.
      if (bus.add_i == SelW'(i)) begin
        req_dec[i] = bus.req_i & ~stall & ~rst_i;
      end
      if (tgt_q == SelW'(i)) begin
        tgt_oh[i] = 1'b1;
        rvld_sel  = bus.rvld_i[i];
        rdata_sel = bus.rdata_i[i];
      end
    end
    accept   = |(req_dec & bus.gnt_i);
    resp_ok  = rvld_sel & ~empty;
    spurious = (|(bus.rvld_i & ~tgt_oh)) | (rvld_sel & empty);
    tgt_d    = accept ? bus.add_i : tgt_q;
    err_d    = spurious;
  end

  outstanding_cnt #(
    .Max (MaxOutstanding)
  ) u_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (accept),
    .dec_i   (resp_ok),
    .cnt_o   (cnt),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tgt_q <= '0;
      err_q <= 1'b0;
    end else begin
      tgt_q <= tgt_d;
      err_q <= err_d;
    end
  end

  generate
    if (RespReg != 0) begin : g_resp_reg
      logic                     rvld_q, rvld_d;
      logic [RespDataWidth-1:0] rdata_q, rdata_d;

      always_comb begin
        rvld_d  = resp_ok;
        rdata_d = resp_ok ? rdata_sel : rdata_q;
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          rvld_q  <= 1'b0;
          rdata_q <= '0;
        end else begin
          rvld_q  <= rvld_d;
          rdata_q <= rdata_d;
        end
      end

      assign bus.rvld_o  = rvld_q;
      assign bus.rdata_o = rdata_q;
    end else begin : g_resp_comb
      assign bus.rvld_o  = resp_ok;
      assign bus.rdata_o = resp_ok ? rdata_sel : '0;
    end
  endgenerate

  assign bus.req_o         = req_dec;
  assign bus.gnt_o         = accept;
  assign bus.err_o         = err_q;
  assign bus.outstanding_o = cnt;
  assign bus.data_o        = {NumSlave{bus.data_i}};

endmodule
